// File: rtl/mem_arbiter_pkg.sv
// Shared RISC-V definitions: bus widths and the arbiter's state/requester types.
// The mem_arbiter round-robin option is selected with MEM_ARBITER_ROUND_ROBIN_EN.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package riscv_defines;

    localparam int unsigned ADDR_W = `RISCV_ADDR_WIDTH;
    localparam int unsigned WORD_W = `RISCV_WORD_WIDTH;
    localparam int unsigned WE_W   = 4;
    localparam int unsigned WAIT_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FETCH = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and shared-memory ports of the memory arbiter.
// master = arbiter side, slave = requesters plus memory.
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

interface mem_arbiter_if;

    logic                         f_valid_i;
    logic [`RISCV_ADDR_WIDTH-1:0] f_addr_i;
    logic                         f_flush_i;
    logic                         f_ready_o;
    logic [`RISCV_WORD_WIDTH-1:0] f_rdata_o;

    logic                         d_valid_i;
    logic [`RISCV_ADDR_WIDTH-1:0] d_addr_i;
    logic [`RISCV_WORD_WIDTH-1:0] d_wdata_i;
    logic [3:0]                   d_we_i;
    logic                         d_ready_o;
    logic [`RISCV_WORD_WIDTH-1:0] d_rdata_o;

    logic                         mem_valid_o;
    logic [`RISCV_ADDR_WIDTH-1:0] mem_addr_o;
    logic [`RISCV_WORD_WIDTH-1:0] mem_wdata_o;
    logic [3:0]                   mem_we_o;
    logic                         mem_ready_i;
    logic [`RISCV_WORD_WIDTH-1:0] mem_rdata_i;

    logic                         timeout_o;

    modport master (
        input  f_valid_i, f_addr_i, f_flush_i,
        output f_ready_o, f_rdata_o,
        input  d_valid_i, d_addr_i, d_wdata_i, d_we_i,
        output d_ready_o, d_rdata_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
        input  mem_ready_i, mem_rdata_i,
        output timeout_o
    );

    modport slave (
        output f_valid_i, f_addr_i, f_flush_i,
        input  f_ready_o, f_rdata_o,
        output d_valid_i, d_addr_i, d_wdata_i, d_we_i,
        input  d_ready_o, d_rdata_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o,
        output mem_ready_i, mem_rdata_i,
        input  timeout_o
    );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// mem_wait_timer: counts stalled cycles of the outstanding access and
// flags the cycle in which the count reaches the limit.
module mem_wait_timer
    import riscv_defines::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              count_i,
    input  logic [WAIT_W-1:0] limit_i,
    output logic              expired_o
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expiry fires on the stall cycle that would bring the count to the limit.
    assign expired_o = count_i &&
        (({1'b0, cnt_q} + 17'd1) == {1'b0, limit_i});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one shared memory port, one access in flight.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is data priority.
module mem_arbiter
    import riscv_defines::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WE_W-1:0]   we_q, we_d;
    logic              flush_q, flush_d;

    logic busy;
    logic expired;
    logic fin;
    logic grant_f;
    logic grant_d;
    logic hit_f;
    logic hit_d;

    assign busy = (state_q != ARB_IDLE);
    assign fin  = busy && (bus.mem_ready_i || expired);

    mem_wait_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!busy),
        .count_i  (busy && !bus.mem_ready_i),
        .limit_i  (WAIT_W'(WAIT_LIMIT)),
        .expired_o(expired)
    );

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    arb_req_t last_q, last_d;

    always_comb begin
        grant_f = bus.f_valid_i &&
                  (!bus.d_valid_i || last_q == REQ_DATA);
        grant_d = bus.d_valid_i && !grant_f;
        last_d  = last_q;
        if (state_q == ARB_IDLE && grant_d) begin
            last_d = REQ_DATA;
        end else if (state_q == ARB_IDLE && grant_f) begin
            last_d = REQ_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= REQ_FETCH;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant_d = bus.d_valid_i;
        grant_f = bus.f_valid_i && !bus.d_valid_i;
    end
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        flush_d = flush_q;
        unique case (state_q)
            ARB_IDLE: begin
                flush_d = 1'b0;
                if (grant_d) begin
                    state_d = ARB_DATA;
                    addr_d  = bus.d_addr_i;
                    wdata_d = bus.d_wdata_i;
                    we_d    = bus.d_we_i;
                end else if (grant_f) begin
                    state_d = ARB_FETCH;
                    addr_d  = bus.f_addr_i;
                    wdata_d = '0;
                    we_d    = '0;
                    flush_d = bus.f_flush_i;
                end
            end
            ARB_FETCH: begin
                flush_d = flush_q || bus.f_flush_i;
                if (fin) state_d = ARB_IDLE;
            end
            ARB_DATA: begin
                if (fin) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            flush_q <= flush_d;
        end
    end

    // A redirect at any point of a fetch hides that fetch's response.
    assign hit_f = rst_n && fin && (state_q == ARB_FETCH) &&
                   !flush_q && !bus.f_flush_i;
    assign hit_d = rst_n && fin && (state_q == ARB_DATA);

    assign bus.f_ready_o = hit_f;
    assign bus.f_rdata_o = (hit_f && bus.mem_ready_i) ?
                           bus.mem_rdata_i : '0;
    assign bus.d_ready_o = hit_d;
    assign bus.d_rdata_o = (hit_d && bus.mem_ready_i) ?
                           bus.mem_rdata_i : '0;

    assign bus.mem_valid_o = rst_n && busy;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_we_o    = we_q;
    assign bus.timeout_o   = rst_n && expired;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with WAIT_LIMIT=4.
// Expectations follow the round-robin build when MEM_ARBITER_ROUND_ROBIN_EN is set.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.WAIT_LIMIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_f(input logic v, input logic [31:0] a,
                         input logic fl);
        bus.f_valid_i = v;
        bus.f_addr_i  = a;
        bus.f_flush_i = fl;
    endtask

    task automatic set_d(input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] we);
        bus.d_valid_i = v;
        bus.d_addr_i  = a;
        bus.d_wdata_i = wd;
        bus.d_we_i    = we;
    endtask

    task automatic set_m(input logic r, input logic [31:0] rd);
        bus.mem_ready_i = r;
        bus.mem_rdata_i = rd;
    endtask

    logic [31:0] exp_addr;

    initial begin
        set_f(0, 0, 0);
        set_d(0, 0, 0, 0);
        set_m(0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        settle();
        chk("rst_mem_valid", 32'(bus.mem_valid_o), 0);
        chk("rst_timeout", 32'(bus.timeout_o), 0);
        chk("rst_mem_addr", bus.mem_addr_o, 0);
        rst_n = 1'b1;

        // fetch 0x100, two wait cycles
        set_f(1, 32'h100, 0);
        settle();
        chk("f1_idle_valid", 32'(bus.mem_valid_o), 0);
        tick();
        set_f(0, 32'hABC, 0);
        settle();
        chk("f1_valid", 32'(bus.mem_valid_o), 1);
        chk("f1_addr", bus.mem_addr_o, 32'h100);
        chk("f1_we", 32'(bus.mem_we_o), 0);
        chk("f1_wait1_rdy", 32'(bus.f_ready_o), 0);
        tick();
        chk("f1_wait2_rdy", 32'(bus.f_ready_o), 0);
        tick();
        set_m(1, 32'hDEADBEEF);
        settle();
        chk("f1_rdy", 32'(bus.f_ready_o), 1);
        chk("f1_rdata", bus.f_rdata_o, 32'hDEADBEEF);
        chk("f1_d_rdy", 32'(bus.d_ready_o), 0);
        chk("f1_timeout", 32'(bus.timeout_o), 0);
        tick();
        settle();
        chk("f1_idle_after", 32'(bus.mem_valid_o), 0);
        chk("idle_ready_ign", 32'(bus.f_ready_o), 0);
        chk("idle_rdata_zero", bus.f_rdata_o, 0);
        set_m(0, 0);

        // contention: data first in both builds
        set_f(1, 32'h200, 0);
        set_d(1, 32'h300, 32'h12345678, 4'hF);
        tick();
        set_m(1, 32'h55);
        settle();
        chk("c1_addr", bus.mem_addr_o, 32'h300);
        chk("c1_wdata", bus.mem_wdata_o, 32'h12345678);
        chk("c1_we", 32'(bus.mem_we_o), 32'hF);
        chk("c1_d_rdy", 32'(bus.d_ready_o), 1);
        chk("c1_d_rdata", bus.d_rdata_o, 32'h55);
        chk("c1_f_rdy", 32'(bus.f_ready_o), 0);
        tick();
        set_d(0, 0, 0, 0);
        set_m(0, 0);
        settle();
        chk("c1_gap", 32'(bus.mem_valid_o), 0);
        tick();
        set_m(1, 32'h66);
        settle();
        chk("c2_addr", bus.mem_addr_o, 32'h200);
        chk("c2_f_rdy", 32'(bus.f_ready_o), 1);
        chk("c2_d_rdata", bus.d_rdata_o, 0);
        tick();
        set_m(0, 0);

        // persistent contention: alternates only with round robin
        set_f(1, 32'h210, 0);
        set_d(1, 32'h310, 0, 0);
        tick();
        set_m(1, 32'h77);
        settle();
        chk("c3_addr", bus.mem_addr_o, 32'h310);
        tick();
        set_m(0, 0);
        tick();
        set_m(1, 32'h88);
        settle();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        exp_addr = 32'h210;
`else
        exp_addr = 32'h310;
`endif
        chk("c4_addr", bus.mem_addr_o, exp_addr);
        tick();
        set_m(0, 0);
        tick();
        set_m(1, 32'h99);
        settle();
        chk("c5_addr", bus.mem_addr_o, 32'h310);
        tick();
        set_m(0, 0);
        set_f(0, 0, 0);
        set_d(0, 0, 0, 0);
        tick();

        // flush while waiting
        set_f(1, 32'h40, 0);
        tick();
        set_f(0, 0, 1);
        settle();
        chk("fl_addr", bus.mem_addr_o, 32'h40);
        chk("fl_rdy_wait", 32'(bus.f_ready_o), 0);
        tick();
        set_f(0, 0, 0);
        tick();
        set_m(1, 32'h1111);
        settle();
        chk("fl_valid", 32'(bus.mem_valid_o), 1);
        chk("fl_rdy", 32'(bus.f_ready_o), 0);
        chk("fl_rdata", bus.f_rdata_o, 0);
        tick();
        set_m(0, 0);
        settle();
        chk("fl_idle", 32'(bus.mem_valid_o), 0);
        // flush in the granting cycle
        set_f(1, 32'h48, 1);
        tick();
        set_f(0, 0, 0);
        set_m(1, 32'h2222);
        settle();
        chk("fl_grant_rdy", 32'(bus.f_ready_o), 0);
        tick();
        set_m(0, 0);
        // plain fetch afterwards is delivered
        set_f(1, 32'h44, 0);
        tick();
        set_f(0, 0, 0);
        set_m(1, 32'h3333);
        settle();
        chk("fl_next_rdy", 32'(bus.f_ready_o), 1);
        chk("fl_next_rdata", bus.f_rdata_o, 32'h3333);
        tick();
        set_m(0, 32'h9999);

        // timeout on 4th wait cycle
        set_d(1, 32'h80, 0, 0);
        tick();
        set_d(0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            settle();
            chk($sformatf("to_w%0d", i), 32'(bus.timeout_o), 0);
            tick();
        end
        chk("to_pulse", 32'(bus.timeout_o), 1);
        chk("to_d_rdy", 32'(bus.d_ready_o), 1);
        chk("to_d_rdata", bus.d_rdata_o, 0);
        tick();
        chk("to_valid_next", 32'(bus.mem_valid_o), 0);
        chk("to_pulse_next", 32'(bus.timeout_o), 0);

        // completion on the limit cycle wins
        set_d(1, 32'h84, 0, 0);
        tick();
        set_d(0, 0, 0, 0);
        tick();
        tick();
        tick();
        set_m(1, 32'h77);
        settle();
        chk("lim_timeout", 32'(bus.timeout_o), 0);
        chk("lim_d_rdy", 32'(bus.d_ready_o), 1);
        chk("lim_d_rdata", bus.d_rdata_o, 32'h77);
        tick();
        set_m(0, 0);

        // reset mid-wait
        set_d(1, 32'h90, 32'hAA, 4'h3);
        tick();
        set_d(0, 0, 0, 0);
        tick();
        rst_n = 1'b0;
        settle();
        chk("rs_during_valid", 32'(bus.mem_valid_o), 0);
        tick();
        chk("rs_valid", 32'(bus.mem_valid_o), 0);
        chk("rs_d_rdy", 32'(bus.d_ready_o), 0);
        chk("rs_timeout", 32'(bus.timeout_o), 0);
        chk("rs_addr", bus.mem_addr_o, 0);
        rst_n = 1'b1;
        set_f(1, 32'h0, 0);
        tick();
        set_f(0, 0, 0);
        set_m(1, 32'hCAFE);
        settle();
        chk("rs_f_rdy", 32'(bus.f_ready_o), 1);
        chk("rs_f_rdata", bus.f_rdata_o, 32'hCAFE);
        tick();
        set_m(0, 0);

        // requester address changes after grant
        set_d(1, 32'h500, 32'h5A5A, 4'h1);
        tick();
        set_d(1, 32'hFFFF, 0, 0);
        settle();
        chk("hold_addr1", bus.mem_addr_o, 32'h500);
        chk("hold_we", 32'(bus.mem_we_o), 1);
        tick();
        chk("hold_addr2", bus.mem_addr_o, 32'h500);
        set_m(1, 0);
        settle();
        chk("hold_addr3", bus.mem_addr_o, 32'h500);
        chk("hold_d_rdy", 32'(bus.d_ready_o), 1);
        tick();
        set_d(0, 0, 0, 0);
        set_m(0, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
